alu_mult_seq: RTL
=================

Name: alu_mult_seq

Overview:
- Multi-cycle unsigned multiply controller that sequences the team's combinational 32-bit ALU (ALU_32bits) through a shift-and-add loop.
- Drives every ALU control/operand input, captures the ALU result `s` at each clock edge, and holds working registers P (partial product), M (multiplicand), Q (multiplier) and an iteration counter.
- Returns the low 32 bits of a*b with a start/busy/done handshake.
- Sits beside the ALU in the datapath and owns it while busy.

Parameters:
- ITER_MAX, 32, maximum loop iterations; equals the operand width. Fixed at 32 for this ALU.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a_in  input  32  multiplicand, captured on accepted start
- b_in  input  32  multiplier, captured on accepted start
- busy  output  1  high in ADD/SHL_M/SHR_Q
- done  output  1  high for exactly one cycle (DONE state)
- product  output  32  P register; valid when done=1; held until next accepted start
- alu_a  output  32  to ALU a
- alu_b  output  32  to ALU b
- alu_c0  output  1  to ALU c_0 (0=add)
- alu_const_var  output  1  to ALU Const_Var (0=use Const_amount)
- alu_shift_dir  output  1  to ALU shift_direction (0=left, 1=right)
- alu_func_class  output  2  to ALU Function_class (00 shift, 01 sub-MSB, 10 add/sub, 11 logic)
- alu_logic_fn  output  2  to ALU Logic_function, always 00
- alu_const_amt  output  5  to ALU Const_amount
- alu_s  input  32  ALU result; combinational, sampled the same cycle it is driven

Behaviour:
- Reset (async, rst_n=0): state=IDLE; P, M, Q, counter=0; busy=0, done=0, product=0. All alu_* outputs read 0 because IDLE decode is all zeros.
- Reset mid-operation aborts immediately. No done is produced; product reads 0.
- ALU outputs are a Moore decode of state plus registers:
  - IDLE/DONE: all zero.
  - ADD: alu_a=P, alu_b=M, func=10, c0=0; P<=alu_s at clock edge.
  - SHL_M: alu_b=M, func=00, dir=0, const_var=0, const_amt=1; M<=alu_s.
  - SHR_Q: alu_b=Q, func=00, dir=1, const_var=0, const_amt=1; Q<=alu_s; counter<=counter+1.
- State transitions:
  - IDLE + start: M<=a_in, Q<=b_in, P<=0, counter<=0. Go to ADD if b_in[0]=1, else SHL_M. With early termination compiled in and b_in=0, go directly to DONE.
  - IDLE, no start: stay in IDLE.
  - ADD -> SHL_M.
  - SHL_M -> SHR_Q.
  - SHR_Q -> DONE if counter==ITER_MAX-1 (last iteration), or if early termination applies (see Optional Feature).
  - SHR_Q, otherwise: go to ADD if alu_s[0]=1, else SHL_M.
  - DONE -> IDLE, unconditionally.
- start is ignored in every state except IDLE, including DONE. A start held high through DONE is accepted in the following IDLE cycle.
- Arithmetic is modulo 2^32: ADD carry-out and bits shifted out of M are discarded. No overflow flag.
- Latency:
  - Per iteration: 2 cycles if the current Q[0]=0, 3 cycles if Q[0]=1.
  - busy count = 2*iterations + popcount(multiplier bits consumed).
  - done asserts the cycle after the last busy cycle.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- Defined:
  - SHR_Q also exits to DONE when alu_s==0, i.e. the remaining multiplier is zero.
  - Iterations = index of the highest set bit of b_in, plus 1.
  - b_in=0 goes IDLE -> DONE with zero busy cycles.
- Undefined: always exactly 32 iterations. busy cycles = 64 + popcount(b_in).

Test Plan:
- a=7, b=6 -> product=42. busy cycles = 8 with the macro, 66 without. done is a single-cycle pulse. During ADD: alu_func_class=10 and alu_c0=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0x00000001. busy = 96 cycles in both builds.
- a=0x12345678, b=0 -> product=0. With the macro, done is 1 cycle after the start edge with busy never high. Without it, busy = 64 cycles.
- a=0x00010000, b=0x00010000 -> product=0x00000000 (wrap). Then pulse start with a=3, b=5 during busy -> ignored; the first product is still 0.
- Start a=9, b=9, assert rst_n=0 for 1 cycle after 4 busy cycles -> busy=0, done=0, product=0, all alu_* = 0. A following run a=9, b=9 -> product=81.
- Hold start high continuously with a=2, b=3 -> back-to-back operations, each giving product=6, with exactly one IDLE cycle between DONE and the next busy.

Source files
------------

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: multi-cycle unsigned 32x32 multiply (low 32 bits)
// built by sequencing the shared combinational ALU through shift-and-add.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   start, a_in, b_in   request and operands (start sampled in IDLE only)
//   busy, done          busy in ADD/SHL_M/SHR_Q, done one cycle in DONE
//   product             partial-product register, valid when done=1
//   alu_*               ALU operand/control drive (Moore decode of state)
//   alu_s               ALU result, registered into P/M/Q each cycle
//
// Build option: define MULT_EARLY_TERM_EN to stop as soon as the
// remaining multiplier is zero (b_in=0 finishes with no busy cycles).
module alu_mult_seq #(
    parameter int ITER_MAX = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_c0,
    output logic        alu_const_var,
    output logic        alu_shift_dir,
    output logic [1:0]  alu_func_class,
    output logic [1:0]  alu_logic_fn,
    output logic [4:0]  alu_const_amt,
    input  logic [31:0] alu_s
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADD   = 3'd1;
    localparam logic [2:0] S_SHL_M = 3'd2;
    localparam logic [2:0] S_SHR_Q = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state;
    logic [31:0] p_reg;
    logic [31:0] m_reg;
    logic [31:0] q_reg;
    logic [5:0]  cnt;

    logic        last_iter;
    logic        q_zero;
    logic        b_zero;
    logic [2:0]  start_next;
    logic [2:0]  shr_next;

    assign last_iter = (cnt == 6'(ITER_MAX - 1));

`ifdef MULT_EARLY_TERM_EN
    // alu_s in SHR_Q is the multiplier after this shift: nothing
    // left to add once it is zero.
    assign q_zero = (alu_s == 32'd0);
    assign b_zero = (b_in == 32'd0);
`else
    assign q_zero = 1'b0;
    assign b_zero = 1'b0;
`endif

    always_comb begin
        start_next = S_SHL_M;
        if (b_zero) begin
            start_next = S_DONE;
        end else if (b_in[0]) begin
            start_next = S_ADD;
        end
    end

    // Next iteration's decision bit is the freshly shifted Q bit 0.
    always_comb begin
        shr_next = S_SHL_M;
        if (last_iter || q_zero) begin
            shr_next = S_DONE;
        end else if (alu_s[0]) begin
            shr_next = S_ADD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            p_reg <= 32'd0;
            m_reg <= 32'd0;
            q_reg <= 32'd0;
            cnt   <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_reg <= a_in;
                        q_reg <= b_in;
                        p_reg <= 32'd0;
                        cnt   <= 6'd0;
                        state <= start_next;
                    end
                end
                S_ADD: begin
                    p_reg <= alu_s;
                    state <= S_SHL_M;
                end
                S_SHL_M: begin
                    m_reg <= alu_s;
                    state <= S_SHR_Q;
                end
                S_SHR_Q: begin
                    q_reg <= alu_s;
                    cnt   <= cnt + 6'd1;
                    state <= shr_next;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode: ALU drive depends only on state and registers,
    // so the ALU result never feeds back into its own inputs.
    always_comb begin
        alu_a          = 32'd0;
        alu_b          = 32'd0;
        alu_c0         = 1'b0;
        alu_const_var  = 1'b0;
        alu_shift_dir  = 1'b0;
        alu_func_class = 2'b00;
        alu_logic_fn   = 2'b00;
        alu_const_amt  = 5'd0;
        case (state)
            S_ADD: begin
                alu_a          = p_reg;
                alu_b          = m_reg;
                alu_func_class = 2'b10;
                alu_c0         = 1'b0;
            end
            S_SHL_M: begin
                alu_b          = m_reg;
                alu_func_class = 2'b00;
                alu_shift_dir  = 1'b0;
                alu_const_var  = 1'b0;
                alu_const_amt  = 5'd1;
            end
            S_SHR_Q: begin
                alu_b          = q_reg;
                alu_func_class = 2'b00;
                alu_shift_dir  = 1'b1;
                alu_const_var  = 1'b0;
                alu_const_amt  = 5'd1;
            end
            default: begin
            end
        endcase
    end

    assign busy    = (state == S_ADD) || (state == S_SHL_M) ||
                     (state == S_SHR_Q);
    assign done    = (state == S_DONE);
    assign product = p_reg;

endmodule
